layer_output_buffer: RTL and testbench
======================================

# layer_output_buffer

Collects the scalar IEEE-754 single-precision dot-product results of one neural layer (one per neuron, produced serially by the vector-multiplication stage) and applies ReLU to each. It packs them into a single output vector and presents that vector with a valid/ready handshake. It sits directly downstream of the dot-product stage. Its packed output has the same element layout as the `A`/`B` vector inputs of the next layer's dot-product stage, so it can drive one of them directly.

## Interface
- `NEURONS`, default 4: number of 32-bit elements per output vector; legal range ≥ 1.
- `clk`  input  1: single clock, all state updates on rising edge.
- `rst_n`  input  1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `clear`  input  1: synchronous discard of a partially filled vector.
- `in_valid`  input  1: `in_data` holds a dot-product result.
- `in_ready`  output  1: block can accept `in_data` this cycle.
- `in_data`  input  32: IEEE-754 single-precision dot-product result.
- `out_valid`  output  1: `out_vector` holds a complete layer result.
- `out_ready`  input  1: consumer accepts `out_vector` this cycle.
- `out_vector`  output  32*NEURONS: element i at bits [32*i +: 32].
- `count`  output  $clog2(NEURONS+1): number of elements stored in the current vector.

## Operation
- Two-state FSM: FILL and FULL.
- Reset (rst_n=0 at an edge):
  - state becomes FILL; `count`=0; `out_valid`=0; `out_vector`=0.
  - `in_data` and `in_valid` are ignored during that cycle.
- `in_ready` = (state==FILL), combinational from state only.
- FILL:
  - Input handshake is in_valid & in_ready at an edge.
  - On a handshake, the transformed `in_data` is written to element `count`, and `count` increments.
  - If `count` was NEURONS-1, the state becomes FULL and `out_valid` becomes 1.
- FULL:
  - `in_ready`=0, so `in_valid` is ignored; `out_vector` and `count` (=NEURONS) are held stable.
  - On out_valid & out_ready at an edge: state returns to FILL, `count`=0, `out_valid`=0.
  - `out_vector` keeps its last contents; stale elements are overwritten as refilling proceeds.
- `clear` (rst_n=1):
  - In FILL: `count`=0 and any handshake that cycle is dropped (nothing written); `clear` has priority over input.
  - In FULL: no effect, because a completed vector is never discarded.
- Element transform, applied at write time:
  - NaN (exponent 8'hFF, mantissa ≠ 0) → canonical 32'h7FC00000.
  - Otherwise, if ReLU is compiled in and sign=1 (including -0 and -Inf) → 32'h00000000.
  - Otherwise pass-through unchanged (+Inf, denormals and +0 preserved bit-exact).
- NEURONS=1: each accepted element moves FILL→FULL immediately.

## Timing
- Element write latency: the value is visible on `out_vector` in the cycle after its handshake edge.
- `out_valid` rises in the cycle after the final (NEURONS-th) handshake.
- `in_ready` falls in that same cycle.
- After the output handshake edge, `in_ready`=1 in the next cycle. There is no same-cycle pass-through, so at least one bubble cycle occurs per vector.
- Maximum sustained throughput: NEURONS elements per NEURONS+1 cycles when `out_ready` is held high.
- Outputs are registered except `in_ready` (decoded from the state register only).
- No combinational path from any input to any output.
- Reset mid-fill or mid-FULL: the partial or complete vector is lost, and the block returns to the reset values above at that edge.

## Configuration
- `LAYER_OUTPUT_RELU_EN` defined: negative non-NaN inputs are stored as +0 (ReLU activation).
- Undefined: the block is a plain packing buffer; non-NaN values are stored bit-exact. NaN canonicalisation applies in both builds.

## Test plan
- Reset release, NEURONS=4: after rst_n=0 then 1 → count=0, out_valid=0, out_vector=0, in_ready=1.
- Fill 4 elements, out_ready=0, inputs 3F800000, 40000000, 40400000, 40800000:
  - out_valid=1 in the cycle after the 4th handshake;
  - out_vector = {40800000, 40400000, 40000000, 3F800000};
  - in_ready=0; a fifth in_valid is ignored while out_ready=0.
- With RELU_EN, input BF800000 → stored 00000000. Without RELU_EN → stored BF800000. Input 7F800001 → 7FC00000 in both builds.
- Partial fill of 2 elements, then clear=1 with in_valid=1 in the same cycle → count=0 and nothing written. The next 4 handshakes produce a vector of only the new values.
- Back-to-back vectors with out_ready tied high:
  - 8 elements offered continuously complete 2 vectors in 10 cycles;
  - exactly one in_ready=0 cycle per vector.
- rst_n=0 pulse while FULL → out_valid=0, count=0, out_vector=0 at the next cycle.

Source files
------------

// File: rtl/layer_output_buffer.sv
// Packs NEURONS serial fp32 dot-product results into one vector (optional ReLU via LAYER_OUTPUT_RELU_EN).
// Latency: element visible 1 cycle after its handshake; in_ready low while a full vector awaits out_ready.
module layer_output_buffer #(
  parameter int NEURONS = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [32*NEURONS-1:0]              out_vector,
  output logic [$clog2(NEURONS+1)-1:0]       count
);

  localparam int CW = $clog2(NEURONS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NEURONS - 1);
  localparam logic [31:0]   CANON_NAN = 32'h7FC0_0000;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   wr_en;
  logic   last_elem;
  logic   [31:0] elem;

  function automatic logic [31:0] transform(input logic [31:0] d);
    logic        is_nan;
    logic [31:0] r;
    is_nan = (d[30:23] == 8'hFF) && (d[22:0] != '0);
    if (is_nan) begin
      r = CANON_NAN;
    end
`ifdef LAYER_OUTPUT_RELU_EN
    else if (d[31]) begin
      r = '0;
    end
`endif
    else begin
      r = d;
    end
    return r;
  endfunction

  // clear outranks the input handshake, and is meaningless once FULL
  assign wr_en     = (state == FILL) && in_valid && !clear;
  assign last_elem = (count == LAST_IDX);
  assign elem      = transform(in_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (wr_en && last_elem) state_nxt = FULL;
      FULL: if (out_ready)          state_nxt = FILL;
      default:                      state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state == FULL) begin
      if (out_ready) count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wr_en) begin
      count <= count + CW'(1);
    end
  end

  // stale elements from the previous vector are simply overwritten on refill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vector <= '0;
    end else begin
      for (int i = 0; i < NEURONS; i++) begin
        if (wr_en && (count == CW'(i))) out_vector[32*i +: 32] <= elem;
      end
    end
  end

endmodule

// File: tb/tb_layer_output_buffer.sv
// Bench for layer_output_buffer: spec-level model compared every cycle plus literal spot checks.
module tb_layer_output_buffer;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
`ifdef LAYER_OUTPUT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [32*N-1:0]   out_vector;
  logic [CW-1:0]     count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_vec [N];
  int          m_cnt = 0;
  bit          m_full = 1'b0;

  layer_output_buffer #(.NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vector(out_vector), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_xform(input logic [31:0] d);
    if (d[30:23] == 8'hFF && d[22:0] != 23'd0) return 32'h7FC00000;
    if (RELU && d[31]) return 32'h0;
    return d;
  endfunction

  function automatic logic [32*N-1:0] m_packed();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = m_vec[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [32*N-1:0] act, input logic [32*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour: a list of N slots, an element count, and a full flag
  always @(posedge clk) begin
    if (!rst_n) begin
      m_full = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < N; i++) m_vec[i] = 32'h0;
    end else if (m_full) begin
      if (out_ready) begin
        m_full = 1'b0;
        m_cnt  = 0;
      end
    end else if (clear) begin
      m_cnt = 0;
    end else if (in_valid) begin
      m_vec[m_cnt] = ref_xform(in_data);
      m_cnt++;
      if (m_cnt == N) m_full = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   in_ready,   !m_full);
      check("out_valid",  out_valid,  m_full);
      check("count",      count,      m_cnt);
      check("out_vector", out_vector, m_packed());
    end
  end

  task automatic push(input logic [31:0] d);
    bit r;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      r = in_ready;
      @(posedge clk);
      if (r) return;
    end
    checks++;
    failures++;
    $display("FAIL push_timeout actual=in_ready_low required=handshake_within_20");
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc, n, vecs, lows;
    bit ir, ov;

    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_count",     count,      0);
    check("rst_out_valid", out_valid,  0);
    check("rst_vector",    out_vector, 0);
    check("rst_in_ready",  in_ready,   1);

    // basic fill with consumer stalled
    push(32'h3F800000); push(32'h40000000); push(32'h40400000); push(32'h40800000);
    idle();
    check("fill_out_valid", out_valid, 1);
    check("fill_in_ready",  in_ready,  0);
    check("fill_vector", out_vector, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_hold_count",  count, 4);
    check("full_hold_vector", out_vector, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_in_ready", in_ready, 1);
    check("drain_count",    count,    0);

    // sign and NaN handling
    push(32'hBF800000); push(32'h7F800001); push(32'h80000000); push(32'hFF800000);
    idle();
    if (RELU)
      check("xform_neg", out_vector, {32'h00000000, 32'h00000000, 32'h7FC00000, 32'h00000000});
    else
      check("xform_neg", out_vector, {32'hFF800000, 32'h80000000, 32'h7FC00000, 32'hBF800000});
    drain();
    push(32'h7F800000); push(32'h00000001); push(32'h00000000); push(32'hFFC00000);
    idle();
    check("xform_pos", out_vector, {32'h7FC00000, 32'h00000000, 32'h00000001, 32'h7F800000});
    drain();

    // clear drops a partial vector and the same-cycle input
    push(32'h11111111); push(32'h22222222);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h33333333;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_count", count, 0);
    push(32'h44444444); push(32'h55555555); push(32'h66666666); push(32'h77777777);
    idle();
    check("clear_refill", out_vector, {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});
    drain();

    // streaming with out_ready held high
    out_ready = 1'b1;
    n = 0; vecs = 0; lows = 0; cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid = (n < 8);
      in_data  = 32'h1000 + n;
      ir = in_ready;
      ov = out_valid;
      if (!ir) lows++;
      @(posedge clk);
      if (ir && n < 8) n++;
      if (ov) vecs++;
      cyc = c;
      if (vecs == 2) break;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_cycles",    cyc,  10);
    check("stream_ready_low", lows, 2);
    check("stream_vector", out_vector, {32'h1007, 32'h1006, 32'h1005, 32'h1004});

    // reset while FULL
    push(32'hAAAA0000); push(32'hAAAA0001); push(32'hAAAA0002); push(32'hAAAA0003);
    idle();
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid",  out_valid,  0);
    check("midrst_count",  count,      0);
    check("midrst_vector", out_vector, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
